// File: rtl/command_responder_pkg.sv
// Shared types and frame layout for the command responder.
// The command width is also used by the system controller.
package command_responder_pkg;

  localparam int CMD_W      = 3;
  localparam int PRE_BITS   = 8;
  localparam int CMD_BITS   = 3;
  localparam int FRAME_BITS = 12;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SEND_PRE = 3'd1;
  localparam logic [2:0] ST_SEND_CMD = 3'd2;
  localparam logic [2:0] ST_SEND_PAR = 3'd3;
  localparam logic [2:0] ST_REARM    = 3'd4;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    SEND_PRE = ST_SEND_PRE,
    SEND_CMD = ST_SEND_CMD,
    SEND_PAR = ST_SEND_PAR,
    REARM    = ST_REARM
  } state_e;

  // Bit on the line for frame position idx: preamble MSB first, command MSB first, parity.
  function automatic logic frame_bit(input logic [3:0] idx, input logic [7:0] pre,
                                     input logic [CMD_W-1:0] cmd, input logic par);
    if (idx < 4'(PRE_BITS))
      return pre[3'd7 - idx[2:0]];
    else if (idx < 4'(PRE_BITS + CMD_BITS))
      return cmd[2'd2 - idx[1:0]];
    else
      return par;
  endfunction

endpackage

// File: rtl/command_responder_bit_tick_gen.sv
// Bit-period down-counter: tick marks the last clock of each serial bit.
// load restarts the period so the first bit of a frame gets its full width.
module command_responder_bit_tick_gen #(
  parameter int unsigned BIT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tick
);

  localparam logic [7:0] RELOAD = 8'(BIT_CYCLES - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = RELOAD;
    else if (en)
      cnt_d = (cnt_q == 8'd0) ? RELOAD : cnt_q - 8'd1;
  end

  assign tick = en && (cnt_q == 8'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt_q <= 8'd0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/command_responder.sv
// Responder side of the controller command handshake: frames the latched
// command as preamble, command, parity on tx_bit, then re-arms.
module command_responder
  import command_responder_pkg::*;
#(
  parameter int unsigned BIT_CYCLES   = 4,
  parameter logic [7:0]  PREAMBLE     = 8'hA5,
  parameter int unsigned REARM_CYCLES = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CMD_W-1:0] command_1,
  input  logic             start,
  output logic             ready_command,
  output logic             tx_bit,
  output logic             tx_active,
  output logic [7:0]       frame_count
);

  // A zero-length re-arm window still spends one clock in REARM.
  localparam logic [7:0] REARM_LOAD = (REARM_CYCLES == 0) ? 8'd0 : 8'(REARM_CYCLES - 1);

  state_e           state_q, state_d;
  logic [3:0]       bit_idx_q, bit_idx_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic             par_q, par_d;
  logic [7:0]       rearm_q, rearm_d;
  logic [7:0]       frame_count_q, frame_count_d;
  logic             ready_q, ready_d;
  logic             tx_bit_q, tx_bit_d;
  logic             tx_active_q, tx_active_d;
  logic             load, sending, tick;
  logic [3:0]       nxt_idx;

  assign sending = (state_q == SEND_PRE) || (state_q == SEND_CMD) || (state_q == SEND_PAR);
  assign nxt_idx = bit_idx_q + 4'd1;

  command_responder_bit_tick_gen #(.BIT_CYCLES(BIT_CYCLES)) u_bit_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .en   (sending),
    .tick (tick)
  );

  always_comb begin
    state_d       = state_q;
    bit_idx_d     = bit_idx_q;
    cmd_d         = cmd_q;
    par_d         = par_q;
    rearm_d       = rearm_q;
    frame_count_d = frame_count_q;
    ready_d       = ready_q;
    tx_bit_d      = tx_bit_q;
    tx_active_d   = tx_active_q;
    load          = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          cmd_d       = command_1;
          par_d       = ^command_1;
          bit_idx_d   = 4'd0;
          load        = 1'b1;
          state_d     = SEND_PRE;
          ready_d     = 1'b0;
          tx_active_d = 1'b1;
          tx_bit_d    = PREAMBLE[7];
        end
      end
      SEND_PRE, SEND_CMD, SEND_PAR: begin
        if (tick) begin
          if (bit_idx_q == 4'(FRAME_BITS - 1)) begin
            state_d       = REARM;
            frame_count_d = frame_count_q + 8'd1;
            rearm_d       = REARM_LOAD;
            ready_d       = 1'b1;
            tx_active_d   = 1'b0;
            tx_bit_d      = 1'b1;
          end else begin
            bit_idx_d = nxt_idx;
            tx_bit_d  = frame_bit(nxt_idx, PREAMBLE, cmd_q, par_q);
            if (nxt_idx < 4'(PRE_BITS))
              state_d = SEND_PRE;
            else if (nxt_idx < 4'(PRE_BITS + CMD_BITS))
              state_d = SEND_CMD;
            else
              state_d = SEND_PAR;
          end
        end
      end
      REARM: begin
        if (rearm_q == 8'd0)
          state_d = IDLE;
        else
          rearm_d = rearm_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      bit_idx_q     <= 4'd0;
      cmd_q         <= '0;
      par_q         <= 1'b0;
      rearm_q       <= 8'd0;
      frame_count_q <= 8'd0;
      ready_q       <= 1'b1;
      tx_bit_q      <= 1'b1;
      tx_active_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_idx_q     <= bit_idx_d;
      cmd_q         <= cmd_d;
      par_q         <= par_d;
      rearm_q       <= rearm_d;
      frame_count_q <= frame_count_d;
      ready_q       <= ready_d;
      tx_bit_q      <= tx_bit_d;
      tx_active_q   <= tx_active_d;
    end
  end

  assign ready_command = ready_q;
  assign tx_bit        = tx_bit_q;
  assign tx_active     = tx_active_q;
  assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_command_responder.sv
// Directed bench: default-timing responder plus a minimum-timing instance for the wrap test.
module tb_command_responder;

  localparam logic [7:0] TB_PRE = 8'hA5;

  logic       clk, rst;
  logic [2:0] command_1, command_2;
  logic       start, start2;
  logic       ready_command, tx_bit, tx_active;
  logic       ready2, tx_bit2, tx_active2;
  logic [7:0] frame_count, frame_count2;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  command_responder dut (
    .clk           (clk),
    .rst           (rst),
    .command_1     (command_1),
    .start         (start),
    .ready_command (ready_command),
    .tx_bit        (tx_bit),
    .tx_active     (tx_active),
    .frame_count   (frame_count)
  );

  command_responder #(.BIT_CYCLES(1), .REARM_CYCLES(0)) dut_min (
    .clk           (clk),
    .rst           (rst),
    .command_1     (command_2),
    .start         (start2),
    .ready_command (ready2),
    .tx_bit        (tx_bit2),
    .tx_active     (tx_active2),
    .frame_count   (frame_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered on the first sampled cycle of a frame; leaves at the first REARM cycle.
  task automatic check_frame(input logic [2:0] c, input bit mid_change);
    logic [11:0] bits;
    bits = {TB_PRE, c, ^c};
    for (int i = 0; i < 48; i++) begin
      chk($sformatf("tx_bit[%0d]", i), 32'(tx_bit), 32'(bits[11 - i/4]));
      chk("tx_active", 32'(tx_active), 32'd1);
      chk("ready_busy", 32'(ready_command), 32'd0);
      if (mid_change && i == 5) begin
        command_1 = 3'b111;
        start     = 1'b0;
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; command_1 = 3'b000;
    start2 = 1'b0; command_2 = 3'b010;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready_command), 32'd1);
    chk("rst_tx_bit", 32'(tx_bit), 32'd1);
    chk("rst_active", 32'(tx_active), 32'd0);
    chk("rst_count", 32'(frame_count), 32'd0);
    rst = 1'b1;
    repeat (4) tick();
    chk("idle_ready", 32'(ready_command), 32'd1);
    chk("idle_active", 32'(tx_active), 32'd0);

    // Single pulsed frame, command 101
    command_1 = 3'b101; start = 1'b1;
    tick();
    start = 1'b0;
    check_frame(3'b101, 1'b0);
    chk("f1_ready", 32'(ready_command), 32'd1);
    chk("f1_active", 32'(tx_active), 32'd0);
    chk("f1_tx_bit", 32'(tx_bit), 32'd1);
    chk("f1_count", 32'(frame_count), 32'd1);
    repeat (11) tick();
    chk("f1_quiet", 32'(tx_active), 32'd0);

    // start held high: back-to-back frames separated by re-arm window
    command_1 = 3'b001; start = 1'b1;
    tick();
    check_frame(3'b001, 1'b0);
    chk("f2_count", 32'(frame_count), 32'd2);
    for (int n = 0; n <= 10; n++) begin
      chk($sformatf("rearm_ready[%0d]", n), 32'(ready_command), 32'd1);
      chk($sformatf("rearm_active[%0d]", n), 32'(tx_active), 32'd0);
      if (n == 4) command_1 = 3'b010;
      tick();
    end
    chk("f3_start_ready", 32'(ready_command), 32'd0);
    chk("f3_start_active", 32'(tx_active), 32'd1);
    start = 1'b0;
    check_frame(3'b010, 1'b0);
    chk("f3_count", 32'(frame_count), 32'd3);
    repeat (11) tick();

    // Mid-frame input changes are ignored
    command_1 = 3'b011; start = 1'b1;
    tick();
    start = 1'b0;
    check_frame(3'b011, 1'b1);
    chk("f4_count", 32'(frame_count), 32'd4);
    repeat (15) tick();
    chk("f4_no_restart", 32'(tx_active), 32'd0);
    chk("f4_ready", 32'(ready_command), 32'd1);

    // Reset during SEND_CMD aborts the frame
    command_1 = 3'b110; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (34) tick();
    chk("pre_abort_active", 32'(tx_active), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("abort_ready", 32'(ready_command), 32'd1);
    chk("abort_tx_bit", 32'(tx_bit), 32'd1);
    chk("abort_active", 32'(tx_active), 32'd0);
    chk("abort_count", 32'(frame_count), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1; command_1 = 3'b100; start = 1'b1;
    tick();
    start = 1'b0;
    check_frame(3'b100, 1'b0);
    chk("f5_count", 32'(frame_count), 32'd1);

    // Minimum timing and frame counter wrap
    start2 = 1'b1;
    for (int f = 0; f < 256; f++) begin
      tick();
      chk("min_first_active", 32'(tx_active2), 32'd1);
      chk("min_first_ready", 32'(ready2), 32'd0);
      repeat (11) tick();
      chk("min_last_active", 32'(tx_active2), 32'd1);
      tick();
      chk("min_rearm_ready", 32'(ready2), 32'd1);
      chk("min_rearm_active", 32'(tx_active2), 32'd0);
      chk("min_count", 32'(frame_count2), 32'((f + 1) % 256));
      tick();
      chk("min_idle_ready", 32'(ready2), 32'd1);
    end
    start2 = 1'b0;
    chk("min_wrap", 32'(frame_count2), 32'd0);
    repeat (3) tick();
    chk("min_stopped", 32'(tx_active2), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
